// File: rtl/membus_master.sv
`timescale 1ns/1ps
// membus_master: single-beat initiator for the 4-bit address / 8-bit data shared memory bus.
// Define MEMBUS_SCAN_EN to add the `scan` input that self-issues wrapping sequential reads.
module membus_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef MEMBUS_SCAN_EN
  input  logic       scan,
`endif
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [3:0] rsp_addr,
  output logic [3:0] address,
  output logic       wr,
  output logic       rd,
  inout  wire  [7:0] databus
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN} state_t;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bus_req_t      req_q, req_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          oe_q, oe_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] rsp_addr_q, rsp_addr_d;
  logic [AW-1:0] address_q, address_d;

`ifdef MEMBUS_SCAN_EN
  logic [AW-1:0] scan_addr_q, scan_addr_d;
  assign req_ready = ready_q & ~scan;
`else
  assign req_ready = ready_q;
`endif

  // Next state, counter, request latch, and registered outputs derived from the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_valid_d = 1'b0;
`ifdef MEMBUS_SCAN_EN
    scan_addr_d = scan_addr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata};
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
        end
`ifdef MEMBUS_SCAN_EN
        else if (scan) begin
          req_d       = '{write: 1'b0, addr: scan_addr_q, wdata: '0};
          scan_addr_d = scan_addr_q + AW'(1);
          state_d     = S_SETUP;
          cnt_d       = CW'(SETUP_CYC - 1);
        end
`endif
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = CW'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          if (!req_q.write) rdata_d = databus;
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_TURN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_TURN: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_addr_d  = req_q.addr;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d   = (state_d == S_IDLE);
    address_d = (state_d == S_SETUP) ? req_d.addr : address_q;
    wr_d      = (state_d == S_STROBE) && req_d.write;
    rd_d      = (state_d == S_STROBE) && !req_d.write;
    // Master drives only through SETUP..HOLD of a write; TURN is the dead cycle before any read
    oe_d      = req_d.write && ((state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      oe_q        <= 1'b0;
      rdata_q     <= '0;
      rsp_addr_q  <= '0;
      address_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      oe_q        <= oe_d;
      rdata_q     <= rdata_d;
      rsp_addr_q  <= rsp_addr_d;
      address_q   <= address_d;
    end
  end

`ifdef MEMBUS_SCAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_addr_q <= '0;
    else        scan_addr_q <= scan_addr_d;
  end
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_addr  = rsp_addr_q;
  assign address   = address_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign databus   = oe_q ? req_q.wdata : {DW{1'bz}};

endmodule

// File: tb/tb_membus_master.sv
`timescale 1ns/1ps
// tb_membus_master: directed requests against a memory responder, checked every cycle by a
// transaction-offset timing model; a released bus reads back 0xFF through pull-ups.
module tb_membus_master;
  localparam int S   = 2;
  localparam int ST  = 4;
  localparam int H   = 1;
  localparam int TOT = S + ST + H + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [3:0] req_addr = 4'h0;
  logic [7:0] req_wdata = 8'h00;
  logic       scan_in = 1'b0;
  logic       req_ready, rsp_valid, wr, rd;
  logic [7:0] rsp_rdata;
  logic [3:0] rsp_addr, address;
  wire  [7:0] databus;

  int checks = 0;
  int errors = 0;

  membus_master #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MEMBUS_SCAN_EN
    .scan      (scan_in),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_addr  (rsp_addr),
    .address   (address),
    .wr        (wr),
    .rd        (rd),
    .databus   (databus)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (databus[g]);
  end

  // Memory responder, preloaded with addr*0x11
  logic [7:0] mem [16];
  logic       mem_loaded = 1'b0;
  assign databus = rd ? mem[address] : 8'bz;
  always @(posedge clk) begin
    if (!rst_n && !mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17);
      mem_loaded <= 1'b1;
    end else if (wr) begin
      mem[address] <= databus;
    end
  end

  // Model: one active transaction, outputs derived from its cycle offset since acceptance
  int         ecount = 0;
  int         acc_edge = -100;
  logic       have_txn = 1'b0;
  logic       t_write = 1'b0;
  logic [3:0] t_addr = 4'h0;
  logic [7:0] t_wdata = 8'h00;
  logic [3:0] exp_address = 4'h0;
  logic [3:0] exp_rsp_addr = 4'h0;
  logic [7:0] exp_rdata = 8'h00;
  logic [3:0] scan_ctr = 4'h0;
  logic [7:0] mem_m [16];
  logic       m_loaded = 1'b0;
  int         cur_off;
  logic       idle_m;

  assign cur_off = ecount - acc_edge;
  assign idle_m  = !have_txn || (cur_off >= TOT);

  always @(posedge clk) begin
    ecount <= ecount + 1;
    if (!rst_n) begin
      if (!m_loaded) begin
        for (int i = 0; i < 16; i++) mem_m[i] <= 8'(i * 17);
        m_loaded <= 1'b1;
      end
      have_txn     <= 1'b0;
      exp_address  <= 4'h0;
      exp_rsp_addr <= 4'h0;
      exp_rdata    <= 8'h00;
      scan_ctr     <= 4'h0;
    end else begin
      if (have_txn && t_write && cur_off >= S + 1 && cur_off <= S + ST) mem_m[t_addr] <= t_wdata;
      if (have_txn && !t_write && cur_off == S + ST) exp_rdata <= mem_m[t_addr];
      if (have_txn && cur_off == TOT - 1) exp_rsp_addr <= t_addr;
      if (idle_m) begin
        if (scan_in) begin
          have_txn    <= 1'b1;
          acc_edge    <= ecount;
          t_write     <= 1'b0;
          t_addr      <= scan_ctr;
          exp_address <= scan_ctr;
          scan_ctr    <= scan_ctr + 4'h1;
        end else if (req_valid) begin
          have_txn    <= 1'b1;
          acc_edge    <= ecount;
          t_write     <= req_write;
          t_addr      <= req_addr;
          t_wdata     <= req_wdata;
          exp_address <= req_addr;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      logic       e_wr, e_rd, e_drv, e_rv, e_ready;
      logic [7:0] e_db, e_rdata;
      logic [3:0] e_addr, e_raddr;
      @(negedge clk);
      if (!rst_n) begin
        e_wr = 1'b0; e_rd = 1'b0; e_rv = 1'b0; e_ready = !scan_in;
        e_db = 8'hFF; e_addr = 4'h0; e_rdata = 8'h00; e_raddr = 4'h0;
      end else begin
        e_wr    = have_txn && t_write && cur_off >= S + 1 && cur_off <= S + ST;
        e_rd    = have_txn && !t_write && cur_off >= S + 1 && cur_off <= S + ST;
        e_drv   = have_txn && t_write && cur_off >= 1 && cur_off <= S + ST + H;
        e_db    = e_drv ? t_wdata : (e_rd ? mem_m[t_addr] : 8'hFF);
        e_rv    = have_txn && cur_off == TOT;
        e_ready = idle_m && !scan_in;
        e_addr  = exp_address;
        e_rdata = exp_rdata;
        e_raddr = exp_rsp_addr;
      end
      chk("wr", 32'(wr), 32'(e_wr));
      chk("rd", 32'(rd), 32'(e_rd));
      chk("wr_rd_excl", 32'(wr & rd), 32'(0));
      chk("databus", 32'(databus), 32'(e_db));
      chk("address", 32'(address), 32'(e_addr));
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
      chk("rsp_addr", 32'(rsp_addr), 32'(e_raddr));
    end
  end

  task automatic do_req(input logic w, input logic [3:0] a, input logic [7:0] d, output int e);
    logic got = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    e = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (have_txn && acc_edge == ecount - 1) begin
        got = 1'b1;
        e   = acc_edge;
      end
    end
    chk("accept", 32'(got), 32'(1));
  endtask

  task automatic wait_rsp(output int cyc, output int nwr, output int nrd);
    logic seen = 1'b0;
    cyc = 0; nwr = 0; nrd = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (wr) nwr++;
      if (rd) nrd++;
      if (rsp_valid) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    chk("rsp_seen", 32'(seen), 32'(1));
  endtask

  initial begin
    int e1, e2, cyc, nwr, nrd, n;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_databus", 32'(databus), 32'(8'hFF));
    chk("rst_address", 32'(address), 32'(0));
    @(posedge clk); #2 rst_n = 1'b1;

`ifdef MEMBUS_SCAN_EN
    @(posedge clk); #2 scan_in = 1'b1;
    n = 0;
    for (int i = 0; i < 400 && n < 17; i++) begin
      @(negedge clk); #1;
      chk("scan_ready", 32'(req_ready), 32'(0));
      if (rsp_valid) begin
        chk("scan_addr", 32'(rsp_addr), 32'(n % 16));
        chk("scan_data", 32'(rsp_rdata), 32'((n % 16) * 17));
        n++;
        if (n == 17) scan_in = 1'b0;
      end
    end
    chk("scan_count", 32'(n), 32'(17));
`endif

    // Write 0xA7 to address 5
    do_req(1'b1, 4'h5, 8'hA7, e1);
    req_valid = 1'b0;
    wait_rsp(cyc, nwr, nrd);
    chk("wr_len", 32'(nwr), 32'(4));
    chk("wr_lat", 32'(cyc), 32'(9));
    chk("wr_rsp_addr", 32'(rsp_addr), 32'(5));

    // Read it back
    do_req(1'b0, 4'h5, 8'h00, e1);
    req_valid = 1'b0;
    wait_rsp(cyc, nwr, nrd);
    chk("rd_len", 32'(nrd), 32'(4));
    chk("rd_lat", 32'(cyc), 32'(9));
    chk("rd_data", 32'(rsp_rdata), 32'(8'hA7));
    chk("rd_addr", 32'(rsp_addr), 32'(5));
    @(negedge clk); #1;
    chk("rsp_pulse", 32'(rsp_valid), 32'(0));

    // Back-to-back write then read with req_valid held high
    do_req(1'b1, 4'h3, 8'h5A, e1);
    do_req(1'b0, 4'h3, 8'h00, e2);
    req_valid = 1'b0;
    chk("b2b_gap", 32'(e2 - e1), 32'(9));
    wait_rsp(cyc, nwr, nrd);
    chk("b2b_data", 32'(rsp_rdata), 32'(8'h5A));
    chk("b2b_addr", 32'(rsp_addr), 32'(3));

    // Top address and an untouched preloaded location
    do_req(1'b1, 4'hF, 8'hF0, e1);
    do_req(1'b0, 4'hF, 8'h00, e1);
    do_req(1'b0, 4'h9, 8'h00, e1);
    req_valid = 1'b0;
    wait_rsp(cyc, nwr, nrd);
    chk("pre_data", 32'(rsp_rdata), 32'(8'h99));
    chk("pre_addr", 32'(rsp_addr), 32'(9));

    // Reset in the middle of a write strobe
    do_req(1'b1, 4'h9, 8'h3C, e1);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("abort_wr_before", 32'(wr), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wr", 32'(wr), 32'(0));
    chk("abort_databus", 32'(databus), 32'(8'hFF));
    chk("abort_rdata", 32'(rsp_rdata), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) n++;
    end
    chk("abort_no_rsp", 32'(n), 32'(0));

    // Partial strobe still wrote the responder; read confirms the bus recovers
    do_req(1'b0, 4'h9, 8'h00, e1);
    req_valid = 1'b0;
    wait_rsp(cyc, nwr, nrd);
    chk("post_lat", 32'(cyc), 32'(9));
    chk("post_data", 32'(rsp_rdata), 32'(8'h3C));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
